matrix_seq: RTL and testbench

Sequencing controller for the 4-lane multiply/adder-tree dot-product datapath. Holds a 4x4 matrix of 8-bit elements and a 4-element 8-bit vector loaded by the host. On `start` it issues the four matrix rows back-to-back into the datapath, drives the datapath's `con_valid` code, and collects the four 20-bit row results. It sits between the host register interface and the `matrix_times` datapath instance.

---
 rtl/matrix_seq.sv | 192 +++++++++++++++++++
 tb/tb_matrix_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/matrix_seq.sv
// Sequencer for the 4-lane dot-product datapath: holds a 4x4 matrix and a vector, issues rows, collects results.
// Optional feature: define MATSEQ_TOTAL_EN to add the 22-bit res_total accumulator and port.
module matrix_seq #(
    parameter int TREE_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_en,
    input  logic [3:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        vec_en,
    input  logic [1:0]  vec_addr,
    input  logic [7:0]  vec_data,
    input  logic        start,
    output logic        busy,
    output logic [7:0]  v0,
    output logic [7:0]  v1,
    output logic [7:0]  v2,
    output logic [7:0]  v3,
    output logic [7:0]  num0,
    output logic [7:0]  num1,
    output logic [7:0]  num2,
    output logic [7:0]  num3,
    output logic [3:0]  con_valid,
    input  logic [19:0] sum_in,
    output logic        res_valid,
    output logic [1:0]  res_row,
    output logic [19:0] res_data,
    output logic        done
`ifdef MATSEQ_TOTAL_EN
    ,
    output logic [21:0] res_total
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          row_q;
    logic                busy_q;
    logic [3:0]          con_valid_q;
    logic                done_q;
    logic [7:0]          mat_q [16];
    logic [7:0]          vec_q [4];
    logic [TREE_LAT-1:0] pipe_vld_q;
    logic [1:0]          pipe_row_q [TREE_LAT];
    logic [3:0]          cnt_q;
    logic                res_valid_q;
    logic [1:0]          res_row_q;
    logic [19:0]         res_data_q;

    logic                issue_s;
    logic                start_acc_s;
    logic                capt_s;
    logic [1:0]          sel_row_s;

    assign issue_s     = (state_q == S_ISSUE);
    assign start_acc_s = (state_q == S_IDLE) && start;
    assign capt_s      = pipe_vld_q[TREE_LAT-1];
    // Outside ISSUE the row mux parks on row 0.
    assign sel_row_s   = issue_s ? row_q : 2'd0;

    assign v0        = mat_q[{sel_row_s, 2'd0}];
    assign v1        = mat_q[{sel_row_s, 2'd1}];
    assign v2        = mat_q[{sel_row_s, 2'd2}];
    assign v3        = mat_q[{sel_row_s, 2'd3}];
    assign num0      = vec_q[0];
    assign num1      = vec_q[1];
    assign num2      = vec_q[2];
    assign num3      = vec_q[3];
    assign busy      = busy_q;
    assign con_valid = con_valid_q;
    assign done      = done_q;
    assign res_valid = res_valid_q;
    assign res_row   = res_row_q;
    assign res_data  = res_data_q;

    // Control FSM with its registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            row_q       <= 2'd0;
            busy_q      <= 1'b0;
            con_valid_q <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_ISSUE;
                        row_q       <= 2'd0;
                        busy_q      <= 1'b1;
                        con_valid_q <= 4'd2;
                    end else begin
                        busy_q      <= 1'b0;
                        con_valid_q <= 4'd0;
                    end
                end
                S_ISSUE: begin
                    row_q <= row_q + 2'd1;
                    if (row_q == 2'd3) begin
                        state_q     <= S_DRAIN;
                        con_valid_q <= 4'd0;
                    end else begin
                        con_valid_q <= 4'd2;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == 4'd4) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    row_q       <= 2'd0;
                    busy_q      <= 1'b0;
                    con_valid_q <= 4'd0;
                end
            endcase
        end
    end

    // Host writes into matrix and vector storage, accepted only while idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mat_q[i] <= 8'd0;
            for (int i = 0; i < 4; i++)  vec_q[i] <= 8'd0;
        end else if (state_q == S_IDLE) begin
            if (ld_en)  mat_q[ld_addr]  <= ld_data;
            if (vec_en) vec_q[vec_addr] <= vec_data;
        end
    end

    // Row tag pipeline matching the adder-tree latency, plus result capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld_q  <= '0;
            for (int i = 0; i < TREE_LAT; i++) pipe_row_q[i] <= 2'd0;
            cnt_q       <= 4'd0;
            res_valid_q <= 1'b0;
            res_row_q   <= 2'd0;
            res_data_q  <= 20'd0;
        end else begin
            pipe_vld_q[0] <= issue_s;
            pipe_row_q[0] <= row_q;
            for (int i = 1; i < TREE_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_row_q[i] <= pipe_row_q[i-1];
            end
            res_valid_q <= capt_s;
            if (capt_s) begin
                res_row_q  <= pipe_row_q[TREE_LAT-1];
                res_data_q <= sum_in;
            end
            if (start_acc_s) begin
                cnt_q <= 4'd0;
            end else if (capt_s) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

`ifdef MATSEQ_TOTAL_EN
    logic [21:0] total_q;
    assign res_total = total_q;

    // Running sum of the row results of the current run.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= 22'd0;
        end else if (start_acc_s) begin
            total_q <= 22'd0;
        end else if (capt_s) begin
            total_q <= total_q + {2'd0, sum_in};
        end
    end
`endif

endmodule

// File: tb/tb_matrix_seq.sv
// Self-checking bench for matrix_seq: two instances (TREE_LAT 2 and 5) fed by behavioural datapath models.
module tb_matrix_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, ld_en, vec_en, start;
    logic [3:0]  ld_addr;
    logic [7:0]  ld_data, vec_data;
    logic [1:0]  vec_addr;

    logic        busy_a, rv_a, done_a, busy_b, rv_b, done_b;
    logic [7:0]  v0_a, v1_a, v2_a, v3_a, n0_a, n1_a, n2_a, n3_a;
    logic [7:0]  v0_b, v1_b, v2_b, v3_b, n0_b, n1_b, n2_b, n3_b;
    logic [3:0]  cv_a, cv_b;
    logic [1:0]  row_a, row_b;
    logic [19:0] data_a, data_b, sum_a, sum_b;
`ifdef MATSEQ_TOTAL_EN
    logic [21:0] tot_a, tot_b;
`endif

    matrix_seq #(.TREE_LAT(2)) u_a (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .vec_en(vec_en), .vec_addr(vec_addr), .vec_data(vec_data), .start(start),
        .busy(busy_a), .v0(v0_a), .v1(v1_a), .v2(v2_a), .v3(v3_a),
        .num0(n0_a), .num1(n1_a), .num2(n2_a), .num3(n3_a), .con_valid(cv_a),
        .sum_in(sum_a), .res_valid(rv_a), .res_row(row_a), .res_data(data_a), .done(done_a)
`ifdef MATSEQ_TOTAL_EN
        , .res_total(tot_a)
`endif
    );

    matrix_seq #(.TREE_LAT(5)) u_b (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .vec_en(vec_en), .vec_addr(vec_addr), .vec_data(vec_data), .start(start),
        .busy(busy_b), .v0(v0_b), .v1(v1_b), .v2(v2_b), .v3(v3_b),
        .num0(n0_b), .num1(n1_b), .num2(n2_b), .num3(n3_b), .con_valid(cv_b),
        .sum_in(sum_b), .res_valid(rv_b), .res_row(row_b), .res_data(data_b), .done(done_b)
`ifdef MATSEQ_TOTAL_EN
        , .res_total(tot_b)
`endif
    );

    function automatic logic [19:0] dot(input logic [7:0] a0, a1, a2, a3, n0, n1, n2, n3);
        return 20'(a0) * 20'(n0) + 20'(a1) * 20'(n1) + 20'(a2) * 20'(n2) + 20'(a3) * 20'(n3);
    endfunction

    // Datapath models: a fixed-latency dot product, random junk when nothing is issued.
    logic [19:0] dpa [2];
    logic [19:0] dpb [5];
    always @(posedge clk) begin
        dpa[0] <= (cv_a == 4'd2) ? dot(v0_a, v1_a, v2_a, v3_a, n0_a, n1_a, n2_a, n3_a) : 20'($urandom);
        dpa[1] <= dpa[0];
        dpb[0] <= (cv_b == 4'd2) ? dot(v0_b, v1_b, v2_b, v3_b, n0_b, n1_b, n2_b, n3_b) : 20'($urandom);
        for (int i = 1; i < 5; i++) dpb[i] <= dpb[i-1];
    end
    assign sum_a = dpa[1];
    assign sum_b = dpb[4];

    logic [7:0] mdl_mat [16];
    logic [7:0] mdl_vec [4];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_all();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 4'(i); ld_data = mdl_mat[i];
            vec_en = (i < 4); vec_addr = 2'(i); vec_data = mdl_vec[i % 4];
        end
        @(negedge clk);
        ld_en = 1'b0; vec_en = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, 32'({busy_a, busy_b}), 32'd0);
        chk({tag, "_cv"}, 32'({cv_a, cv_b}), 32'd0);
        chk({tag, "_rv_done"}, 32'({rv_a, rv_b, done_a, done_b}), 32'd0);
        chk({tag, "_row"}, 32'({row_a, row_b}), 32'd0);
        chk({tag, "_data_a"}, 32'(data_a), 32'd0);
        chk({tag, "_data_b"}, 32'(data_b), 32'd0);
        chk({tag, "_v"}, {v0_a, v1_a, v2_a, v3_a}, 32'd0);
        chk({tag, "_num"}, {n0_b, n1_b, n2_b, n3_b}, 32'd0);
    endtask

    // pokes: bit0 = stray starts in cycles 2 and 6, bit1 = write during ISSUE, bit2 = write with start
    task automatic run_case(input int pokes);
        int exp_r [4];
        int exp_tot;
        @(negedge clk);
        start = 1'b1;
        if (pokes[2]) begin
            ld_en = 1'b1; ld_addr = 4'd0; ld_data = 8'($urandom_range(1, 255));
            mdl_mat[0] = ld_data;
        end
        exp_tot = 0;
        for (int r = 0; r < 4; r++) begin
            exp_r[r] = 0;
            for (int c = 0; c < 4; c++) exp_r[r] += int'(mdl_mat[r*4+c]) * int'(mdl_vec[c]);
            exp_tot += exp_r[r];
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0; ld_en = 1'b0;
            chk("a_busy", 32'(busy_a), 32'(c >= 1 && c <= 8));
            chk("b_busy", 32'(busy_b), 32'(c >= 1 && c <= 11));
            chk("a_cv", 32'(cv_a), (c >= 1 && c <= 4) ? 32'd2 : 32'd0);
            chk("b_cv", 32'(cv_b), (c >= 1 && c <= 4) ? 32'd2 : 32'd0);
            if (c <= 4)
                chk("a_vrow", {v0_a, v1_a, v2_a, v3_a},
                    {mdl_mat[(c-1)*4], mdl_mat[(c-1)*4+1], mdl_mat[(c-1)*4+2], mdl_mat[(c-1)*4+3]});
            chk("a_rv", 32'(rv_a), 32'(c >= 4 && c <= 7));
            if (c >= 4 && c <= 7) begin
                chk("a_row", 32'(row_a), 32'(c - 4));
                chk("a_data", 32'(data_a), 32'(exp_r[c-4]));
            end
            chk("b_rv", 32'(rv_b), 32'(c >= 7 && c <= 10));
            if (c >= 7 && c <= 10) begin
                chk("b_row", 32'(row_b), 32'(c - 7));
                chk("b_data", 32'(data_b), 32'(exp_r[c-7]));
            end
            chk("a_done", 32'(done_a), 32'(c == 8));
            chk("b_done", 32'(done_b), 32'(c == 11));
`ifdef MATSEQ_TOTAL_EN
            if (c == 8 || c == 12) chk("a_total", 32'(tot_a), 32'(exp_tot));
            if (c >= 11) chk("b_total", 32'(tot_b), 32'(exp_tot));
`endif
            if (pokes[0] && (c == 2 || c == 6)) start = 1'b1;
            if (pokes[1] && c == 2) begin
                ld_en = 1'b1; ld_addr = 4'd5; ld_data = 8'd9;
            end
        end
        chk("a_hold", 32'(data_a), 32'(exp_r[3]));
        chk("b_hold", 32'(data_b), 32'(exp_r[3]));
        chk("num", {n0_a, n1_a, n2_a, n3_a}, {mdl_vec[0], mdl_vec[1], mdl_vec[2], mdl_vec[3]});
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ld_en = 1'b0; vec_en = 1'b0;
        ld_addr = 4'd0; ld_data = 8'd0; vec_addr = 2'd0; vec_data = 8'd0;
        repeat (3) @(negedge clk);
        check_zero_outputs("rst");
        reset = 1'b1;

        // Identity matrix times {1,2,3,4}
        for (int i = 0; i < 16; i++) mdl_mat[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
        for (int i = 0; i < 4; i++) mdl_vec[i] = 8'(i + 1);
        load_all();
        run_case(0);

        // Full-scale operands
        for (int i = 0; i < 16; i++) mdl_mat[i] = 8'd255;
        for (int i = 0; i < 4; i++) mdl_vec[i] = 8'd255;
        load_all();
        run_case(0);

        // Random operands with stray starts, a dropped write, then an untouched rerun
        for (int i = 0; i < 16; i++) mdl_mat[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mdl_vec[i] = 8'($urandom);
        load_all();
        run_case(1);
        run_case(2);
        run_case(0);
        run_case(4);

        // Row 2 = {1,0,0,0} with vector[0] = 7
        for (int i = 0; i < 16; i++) mdl_mat[i] = 8'($urandom);
        for (int i = 8; i < 12; i++) mdl_mat[i] = (i == 8) ? 8'd1 : 8'd0;
        mdl_vec[0] = 8'd7;
        for (int i = 1; i < 4; i++) mdl_vec[i] = 8'($urandom);
        load_all();
        run_case(0);

        // Reset asserted in cycle 3 of a run
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk) start = 1'b0;
        reset = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) mdl_mat[i] = 8'd0;
        for (int i = 0; i < 4; i++) mdl_vec[i] = 8'd0;
        run_case(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
